// File: rtl/send_mem_fsm.sv
// Debug-unit uploader: sends a word-count byte, then N memory words MSB byte first over UART TX.
// Latency: first data byte 3 cycles after the count byte's tx_done; 4 cycles between words.
// Backpressure: each byte waits for i_tx_done before the next tx_start; i_start is ignored while busy.
module send_mem_fsm #(
  parameter int UART_BITS = 8,
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [ADDR_BITS-1:0] i_base_addr,
  input  logic [UART_BITS-1:0] i_word_count,
  input  logic [DATA_BITS-1:0] i_mem_data,
  input  logic                 i_tx_done,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic                 o_tx_start,
  output logic [UART_BITS-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BYTES = DATA_BITS / UART_BITS;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  typedef enum logic [3:0] {
    IDLE,
    SEND_CNT,
    WAIT_CNT,
    READ_MEM,
    LATCH,
    SEND_BYTE,
    WAIT_BYTE,
    NEXT_WORD,
    FINISH
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] addr, addr_nxt;
  logic [UART_BITS-1:0] remaining, remaining_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [BC_W-1:0]      byte_cnt, byte_cnt_nxt;
  logic [UART_BITS-1:0] tx_data_q, tx_data_nxt;

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      shift     <= '0;
      byte_cnt  <= '0;
      tx_data_q <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      shift     <= shift_nxt;
      byte_cnt  <= byte_cnt_nxt;
      tx_data_q <= tx_data_nxt;
    end
  end

  // Next-state, datapath updates and Moore-style outputs.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    shift_nxt     = shift;
    byte_cnt_nxt  = byte_cnt;
    tx_data_nxt   = tx_data_q;
    o_mem_addr    = '0;
    o_tx_start    = 1'b0;
    o_tx_data     = tx_data_q;  // last byte stays visible through wait states
    o_busy        = 1'b1;
    o_done        = 1'b0;

    case (state)
      IDLE: begin
        o_busy      = 1'b0;
        o_tx_data   = '0;
        tx_data_nxt = '0;
        if (i_start) begin
          addr_nxt      = i_base_addr;
          remaining_nxt = i_word_count;
          state_nxt     = SEND_CNT;
        end
      end
      SEND_CNT: begin
        o_tx_start  = 1'b1;
        o_tx_data   = remaining;
        tx_data_nxt = remaining;
        state_nxt   = WAIT_CNT;
      end
      WAIT_CNT: begin
        if (i_tx_done) begin
          // A zero count still reports the count byte but never touches memory.
          state_nxt = (remaining == '0) ? FINISH : READ_MEM;
        end
      end
      READ_MEM: begin
        o_mem_addr = addr;
        state_nxt  = LATCH;
      end
      LATCH: begin
        // Synchronous memory: data for the address presented in READ_MEM is valid now.
        o_mem_addr   = addr;
        shift_nxt    = i_mem_data;
        byte_cnt_nxt = '0;
        state_nxt    = SEND_BYTE;
      end
      SEND_BYTE: begin
        o_mem_addr  = addr;
        o_tx_start  = 1'b1;
        o_tx_data   = shift[DATA_BITS-1 -: UART_BITS];
        tx_data_nxt = shift[DATA_BITS-1 -: UART_BITS];
        state_nxt   = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        o_mem_addr = addr;
        if (i_tx_done) begin
          shift_nxt    = shift << UART_BITS;
          byte_cnt_nxt = byte_cnt + BC_W'(1);
          state_nxt    = (byte_cnt == LAST_BYTE) ? NEXT_WORD : SEND_BYTE;
        end
      end
      NEXT_WORD: begin
        o_mem_addr    = addr;
        addr_nxt      = addr + ADDR_BITS'(1);  // wraps at the top of memory
        remaining_nxt = remaining - UART_BITS'(1);
        state_nxt     = (remaining == UART_BITS'(1)) ? FINISH : READ_MEM;
      end
      FINISH: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
